// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline stall/flush controller.
// Used by pipe_ctrl and md_seq.
package pipe_pkg;

    localparam logic [1:0]  TUSE_NEVER   = 2'd3;
    localparam logic [31:0] EXC_ENTRY    = 32'h00004180;
    localparam int          DEF_MULT_LAT = 5;
    localparam int          DEF_DIV_LAT  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/pipe_ctrl_md_seq.sv
// Multiply/divide busy sequencer: counts down the MDU latency after an accepted start.
//
// state | meaning
// IDLE  | MDU free, a start that is not killed loads the latency
// BUSY  | operation in flight, cnt counts down to 1 then returns to IDLE
module md_seq
    import pipe_pkg::*;
#(
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic is_div,
    input  logic kill,
    output logic busy
);

    md_state_t        state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // a start flushed by an exception never reaches the MDU
                    if (start && !kill) begin
                        cnt   <= is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == CNT_W'(1)) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // start is folded in combinationally so a trailing md instruction stalls at once
    assign busy = !rst && (start || (state == BUSY));

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush scheduler for the five-stage pipeline: Tuse/Tnew hazards, MDU busy, exception entry.
// Build option STALL_PERF_EN adds the stall_cnt and md_stall_cnt performance counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_rs_tuse,
    input  logic [1:0] D_rt_tuse,
    input  logic       D_is_md,
    input  logic [4:0] E_wa,
    input  logic [1:0] E_tnew,
    input  logic [4:0] M_wa,
    input  logic [1:0] M_tnew,
    input  logic       E_md_start,
    input  logic       E_md_is_div,
    input  logic       cp0_req,
    output logic       req,
    output logic       stall,
    output logic       de_clr,
    output logic       md_busy
`ifdef STALL_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] md_stall_cnt
`endif
);

    logic hz_rs;
    logic hz_rt;
    logic md_stall;

    assign hz_rs = (D_rs != 5'd0) &&
                   (((E_wa == D_rs) && (E_tnew > D_rs_tuse)) ||
                    ((M_wa == D_rs) && (M_tnew > D_rs_tuse)));
    assign hz_rt = (D_rt != 5'd0) &&
                   (((E_wa == D_rt) && (E_tnew > D_rt_tuse)) ||
                    ((M_wa == D_rt) && (M_tnew > D_rt_tuse)));

    md_seq #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_md_seq (
        .clk    (clk),
        .rst    (rst),
        .start  (E_md_start),
        .is_div (E_md_is_div),
        .kill   (cp0_req),
        .busy   (md_busy)
    );

    assign md_stall = D_is_md && md_busy;

    // exception entry flushes everything, so holding F/D would be pointless
    assign req    = !rst && cp0_req;
    assign stall  = !rst && !cp0_req && (hz_rs || hz_rt || md_stall);
    assign de_clr = stall;

`ifdef STALL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt    <= '0;
            md_stall_cnt <= '0;
        end else begin
            if (stall)
                stall_cnt <= stall_cnt + 32'd1;
            if (stall && md_stall)
                md_stall_cnt <= md_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
